// File: rtl/sqrt_pkg.sv
// Shared widths and dispatcher FSM encoding for the square-root datapath.
package sqrt_pkg;
    localparam int SQ_D_W = 32;
    localparam int SQ_Q_W = 16;
    localparam int SQ_R_W = 17;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } sqrt_state_t;
endpackage

// File: rtl/sqrt_operand_fifo.sv
// Operand FIFO for the square-root dispatcher: DEPTH-entry synchronous queue,
// head always shows the oldest entry.
module sqrt_operand_fifo
    import sqrt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [SQ_D_W-1:0]      din,
    output logic [SQ_D_W-1:0]      head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [SQ_D_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic              do_push_s;
    logic              do_pop_s;

    // Refuse overflow and underflow locally so a misbehaving caller cannot corrupt the queue
    always_comb begin
        do_push_s = push && (count != FULL_CNT);
        do_pop_s  = pop && (count != '0);
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count    <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage: entries beyond count are never observed, so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign head = mem_r[rd_ptr_r];
endmodule

// File: rtl/sqrt_dispatcher.sv
// Square-root dispatcher: queues radicands, runs one core operation at a time
// and holds each result for a backpressured consumer. SQRT_DISP_EXACT_EN adds out_exact.
module sqrt_dispatcher
    import sqrt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SQ_D_W-1:0] in_d,
    output logic              sq_start,
    output logic [SQ_D_W-1:0] sq_d,
    input  logic              sq_busy,
    input  logic              sq_ready,
    input  logic [SQ_Q_W-1:0] sq_q,
    input  logic [SQ_R_W-1:0] sq_r,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SQ_D_W-1:0] out_d,
    output logic [SQ_Q_W-1:0] out_q,
    output logic [SQ_R_W-1:0] out_r
`ifdef SQRT_DISP_EXACT_EN
    ,
    output logic              out_exact
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    sqrt_state_t       state_r;
    logic [CNT_W-1:0]  count_s;
    logic [SQ_D_W-1:0] head_s;
    logic              push_s;
    logic              issue_s;
    logic              capture_s;
    logic              drain_s;

    assign in_ready = (count_s != FULL_CNT);

    // Handshake decode; an issue may reuse the output slot that drains on the same edge
    always_comb begin
        push_s    = in_valid && in_ready;
        drain_s   = out_valid && out_ready;
        issue_s   = (state_r == IDLE) && (count_s != '0) && !sq_busy && (!out_valid || out_ready);
        capture_s = (state_r == WAIT) && sq_ready;
    end

    sqrt_operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .push  (push_s),
        .pop   (issue_s),
        .din   (in_d),
        .head  (head_s),
        .count (count_s)
    );

    // Issue FSM: sq_d keeps the issued operand so the capture can echo it on out_d
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r  <= IDLE;
            sq_start <= 1'b0;
            sq_d     <= '0;
        end else begin
            sq_start <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        sq_start <= 1'b1;
                        sq_d     <= head_s;
                        state_r  <= WAIT;
                    end
                end
                WAIT: begin
                    if (capture_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Output holding register; a capture wins over a same-edge drain
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            out_valid <= 1'b0;
            out_d     <= '0;
            out_q     <= '0;
            out_r     <= '0;
`ifdef SQRT_DISP_EXACT_EN
            out_exact <= 1'b0;
`endif
        end else if (capture_s) begin
            out_valid <= 1'b1;
            out_d     <= sq_d;
            out_q     <= sq_q;
            out_r     <= sq_r;
`ifdef SQRT_DISP_EXACT_EN
            out_exact <= (sq_r == '0);
`endif
        end else if (drain_s) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end
endmodule

// File: tb/tb_sqrt_dispatcher.sv
// Self-checking bench for sqrt_dispatcher with a behavioural square-root core model.
`timescale 1ns/1ps
module tb_sqrt_dispatcher;
    localparam int DEPTH = 4;
    localparam int RND_N = 40;

    logic        clk = 1'b0;
    logic        clrn;
    logic        in_valid, in_ready;
    logic [31:0] in_d;
    logic        sq_start;
    logic [31:0] sq_d;
    logic        sq_busy, sq_ready;
    logic [15:0] sq_q;
    logic [16:0] sq_r;
    logic        out_valid, out_ready;
    logic [31:0] out_d;
    logic [15:0] out_q;
    logic [16:0] out_r;
`ifdef SQRT_DISP_EXACT_EN
    logic        out_exact;
`endif

    int vectors = 0;
    int miscompares = 0;
    int accepted = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    sqrt_dispatcher #(.DEPTH(DEPTH)) dut (
        .clk(clk), .clrn(clrn),
        .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
        .sq_start(sq_start), .sq_d(sq_d), .sq_busy(sq_busy), .sq_ready(sq_ready),
        .sq_q(sq_q), .sq_r(sq_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_d(out_d), .out_q(out_q), .out_r(out_r)
`ifdef SQRT_DISP_EXACT_EN
        , .out_exact(out_exact)
`endif
    );

    // Reference: largest q with q*q <= d, by binary search over [0, 65536)
    function automatic logic [15:0] ref_root(input logic [31:0] d);
        longint unsigned dd, lo, hi, mid;
        dd = {32'd0, d};
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= dd) lo = mid;
            else hi = mid;
        end
        return 16'(lo);
    endfunction

    function automatic logic [16:0] ref_rem(input logic [31:0] d);
        longint unsigned dd, q;
        dd = {32'd0, d};
        q = {48'd0, ref_root(d)};
        return 17'(dd - q * q);
    endfunction

    // Behavioural core: busy for a random latency after start, then a one-cycle result pulse
    int          core_lat_min = 1, core_lat_max = 1;
    int          core_cnt;
    logic        core_run, core_busy, core_ready;
    logic [31:0] core_d;
    logic [15:0] core_q;
    logic [16:0] core_r;
    logic        inj_ready;
    logic [15:0] inj_q;
    logic [16:0] inj_r;

    assign sq_busy  = core_busy;
    assign sq_ready = core_ready | inj_ready;
    assign sq_q     = inj_ready ? inj_q : core_q;
    assign sq_r     = inj_ready ? inj_r : core_r;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            core_run <= 1'b0; core_busy <= 1'b0; core_ready <= 1'b0;
            core_cnt <= 0; core_d <= '0; core_q <= '0; core_r <= '0;
        end else begin
            core_ready <= 1'b0;
            if (core_run) begin
                if (core_cnt <= 1) begin
                    core_run <= 1'b0; core_busy <= 1'b0; core_ready <= 1'b1;
                    core_q <= ref_root(core_d); core_r <= ref_rem(core_d);
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end else if (sq_start) begin
                core_run <= 1'b1; core_busy <= 1'b1; core_d <= sq_d;
                core_cnt <= int'($urandom_range(core_lat_max, core_lat_min));
            end
        end
    end

    always @(posedge clk) begin
        if (sq_start) start_cnt <= start_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        in_valid = 1'b0; in_d = '0; out_ready = 1'b0;
        inj_ready = 1'b0; inj_q = '0; inj_r = '0;
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    // Offer one operand until accepted or the cycle budget runs out
    task automatic send(input logic [31:0] d, input int budget);
        bit rdy;
        int t;
        t = 0;
        in_valid = 1'b1;
        in_d = d;
        do begin
            rdy = in_ready;
            @(negedge clk);
            t++;
        end while (!rdy && t < budget);
        in_valid = 1'b0;
        if (rdy) accepted++;
        else begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: operand %0h not accepted within %0d cycles", d, budget);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (sq_start !== 1'b0) begin miscompares++; $display("FAIL reset_sq_start: got %0b want 0", sq_start); end
        vectors++; if (sq_d !== 32'd0) begin miscompares++; $display("FAIL reset_sq_d: got %0h want 0", sq_d); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        vectors++; if ({out_d, out_q, out_r} !== 65'd0) begin miscompares++; $display("FAIL reset_out_data: got d=%0h q=%0h r=%0h want 0", out_d, out_q, out_r); end
`ifdef SQRT_DISP_EXACT_EN
        vectors++; if (out_exact !== 1'b0) begin miscompares++; $display("FAIL reset_out_exact: got %0b want 0", out_exact); end
`endif
    endtask

    task automatic test_single();
        int  t;
        bit  prev;
        core_lat_min = 4; core_lat_max = 4;
        out_ready = 1'b0;
        in_valid = 1'b1; in_d = 32'd7000000;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++; if (sq_start !== 1'b0) begin miscompares++; $display("FAIL single_no_bypass: got %0b want 0", sq_start); end
        @(negedge clk);
        vectors++; if (sq_start !== 1'b1) begin miscompares++; $display("FAIL single_issue: got %0b want 1", sq_start); end
        vectors++; if (sq_d !== 32'd7000000) begin miscompares++; $display("FAIL single_sq_d: got %0d want 7000000", sq_d); end
        @(negedge clk);
        vectors++; if (sq_start !== 1'b0) begin miscompares++; $display("FAIL single_start_width: got %0b want 0", sq_start); end
        t = 0; prev = 1'b0;
        while (!out_valid && t < 60) begin prev = sq_ready; @(negedge clk); t++; end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_timeout: out_valid got %0b want 1", out_valid); end
        vectors++; if (prev !== 1'b1) begin miscompares++; $display("FAIL single_capture_latency: sq_ready one cycle earlier got %0b want 1", prev); end
        repeat (3) @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_hold: out_valid got %0b want 1", out_valid); end
        vectors++; if (out_d !== 32'd7000000) begin miscompares++; $display("FAIL single_out_d: got %0d want 7000000", out_d); end
        vectors++; if (out_q !== 16'd2645) begin miscompares++; $display("FAIL single_out_q: got %0d want 2645", out_q); end
        vectors++; if (out_r !== 17'd3975) begin miscompares++; $display("FAIL single_out_r: got %0d want 3975", out_r); end
`ifdef SQRT_DISP_EXACT_EN
        vectors++; if (out_exact !== 1'b0) begin miscompares++; $display("FAIL single_out_exact: got %0b want 0", out_exact); end
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain: out_valid got %0b want 0", out_valid); end
    endtask

    logic [31:0] b2b_d [3];
    logic [15:0] b2b_q [3];
    logic [16:0] b2b_r [3];

    task automatic test_back_to_back();
        b2b_d = '{32'd0, 32'd144, 32'hFFFF_FFFF};
        b2b_q = '{16'd0, 16'd12, 16'd65535};
        b2b_r = '{17'd0, 17'd0, 17'd131070};
        core_lat_min = 3; core_lat_max = 3;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) send(b2b_d[i], 20);
            end
            begin
                int got, t, last_t;
                got = 0; t = 0; last_t = 0;
                while (got < 3 && t < 200) begin
                    if (out_valid) begin
                        if (out_d !== b2b_d[got] || out_q !== b2b_q[got] || out_r !== b2b_r[got]) begin
                            miscompares++;
                            $display("FAIL b2b_result%0d: got d=%0h q=%0d r=%0d want d=%0h q=%0d r=%0d",
                                     got, out_d, out_q, out_r, b2b_d[got], b2b_q[got], b2b_r[got]);
                        end
                        vectors++;
`ifdef SQRT_DISP_EXACT_EN
                        vectors++; if (out_exact !== (got != 2)) begin miscompares++; $display("FAIL b2b_exact%0d: got %0b want %0b", got, out_exact, got != 2); end
`endif
                        // start-to-result latency of the core is lat+1, plus two dispatcher cycles
                        if (got > 0) begin
                            vectors++;
                            if (t - last_t != (core_lat_max + 1) + 2) begin
                                miscompares++;
                                $display("FAIL b2b_throughput%0d: got %0d cycles want %0d", got, t - last_t, core_lat_max + 3);
                            end
                        end
                        last_t = t;
                        got++;
                    end
                    @(negedge clk);
                    t++;
                end
                vectors++; if (got != 3) begin miscompares++; $display("FAIL b2b_count: got %0d results want 3", got); end
            end
        join
        out_ready = 1'b0;
    endtask

    logic [31:0] bp_ops [6];
    bit          bp_done;

    task automatic test_backpressure();
        int acc0, st0, got, t;
        core_lat_min = 2; core_lat_max = 5;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) bp_ops[i] = $urandom();
        acc0 = accepted; st0 = start_cnt; bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(bp_ops[i], 400);
                bp_done = 1'b1;
            end
        join_none
        repeat (40) @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_held: out_valid got %0b want 1", out_valid); end
        vectors++; if (out_d !== bp_ops[0]) begin miscompares++; $display("FAIL bp_held_d: got %0h want %0h", out_d, bp_ops[0]); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full: in_ready got %0b want 0", in_ready); end
        vectors++; if (accepted - acc0 != 5) begin miscompares++; $display("FAIL bp_accepted: got %0d want 5", accepted - acc0); end
        vectors++; if (start_cnt - st0 != 1) begin miscompares++; $display("FAIL bp_issues: got %0d want 1", start_cnt - st0); end
        out_ready = 1'b1;
        got = 0; t = 0;
        while (got < 6 && t < 600) begin
            if (out_valid) begin
                vectors++;
                if (out_d !== bp_ops[got] || out_q !== ref_root(bp_ops[got]) || out_r !== ref_rem(bp_ops[got])) begin
                    miscompares++;
                    $display("FAIL bp_drain%0d: got d=%0h q=%0d r=%0d want d=%0h q=%0d r=%0d", got, out_d, out_q, out_r,
                             bp_ops[got], ref_root(bp_ops[got]), ref_rem(bp_ops[got]));
                end
                got++;
            end
            @(negedge clk);
            t++;
        end
        vectors++; if (got != 6) begin miscompares++; $display("FAIL bp_drain_count: got %0d want 6", got); end
        t = 0;
        while (!bp_done && t < 500) begin @(negedge clk); t++; end
        out_ready = 1'b0;
    endtask

    logic [31:0] dp_d [2];

    task automatic test_drain_push();
        int t;
        dp_d[0] = $urandom();
        dp_d[1] = $urandom();
        core_lat_min = 3; core_lat_max = 3;
        out_ready = 1'b0;
        send(dp_d[0], 20);
        t = 0;
        while (!out_valid && t < 60) begin @(negedge clk); t++; end
        vectors++; if (out_d !== dp_d[0]) begin miscompares++; $display("FAIL dp_first: got %0h want %0h", out_d, dp_d[0]); end
        out_ready = 1'b1; in_valid = 1'b1; in_d = dp_d[1];
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL dp_drained: out_valid got %0b want 0", out_valid); end
        vectors++; if (sq_start !== 1'b0) begin miscompares++; $display("FAIL dp_no_bypass: sq_start got %0b want 0", sq_start); end
        @(negedge clk);
        vectors++; if (sq_start !== 1'b1 || sq_d !== dp_d[1]) begin miscompares++; $display("FAIL dp_issue: sq_start=%0b sq_d=%0h want 1 %0h", sq_start, sq_d, dp_d[1]); end
        t = 0;
        while (!out_valid && t < 60) begin @(negedge clk); t++; end
        vectors++;
        if (out_d !== dp_d[1] || out_q !== ref_root(dp_d[1]) || out_r !== ref_rem(dp_d[1])) begin
            miscompares++;
            $display("FAIL dp_result: got d=%0h q=%0d r=%0d want d=%0h q=%0d r=%0d", out_d, out_q, out_r,
                     dp_d[1], ref_root(dp_d[1]), ref_rem(dp_d[1]));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_spurious();
        inj_q = 16'($urandom()); inj_r = 17'($urandom()); inj_ready = 1'b1;
        @(negedge clk);
        inj_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL spur_valid: got %0b want 0", out_valid); end
        vectors++;
        if (out_d !== dp_d[1] || out_q !== ref_root(dp_d[1]) || out_r !== ref_rem(dp_d[1])) begin
            miscompares++;
            $display("FAIL spur_data: got d=%0h q=%0d r=%0d want d=%0h q=%0d r=%0d", out_d, out_q, out_r,
                     dp_d[1], ref_root(dp_d[1]), ref_rem(dp_d[1]));
        end
        vectors++; if (sq_start !== 1'b0) begin miscompares++; $display("FAIL spur_start: got %0b want 0", sq_start); end
    endtask

    logic [31:0] rnd_ops [RND_N];

    task automatic test_random();
        logic [31:0] k;
        core_lat_min = 1; core_lat_max = 6;
        for (int i = 0; i < RND_N; i++) begin
            k = 32'($urandom_range(65535, 0));
            case ($urandom_range(4, 0))
                0:       rnd_ops[i] = k * k;
                1:       rnd_ops[i] = (k * k) - 32'd1;
                2:       rnd_ops[i] = 32'($urandom_range(15, 0));
                default: rnd_ops[i] = $urandom();
            endcase
        end
        fork
            begin
                for (int i = 0; i < RND_N; i++) begin
                    repeat ($urandom_range(3, 0)) @(negedge clk);
                    send(rnd_ops[i], 200);
                end
            end
            begin
                int got, t;
                longint unsigned qq, rr, dd;
                got = 0; t = 0;
                while (got < RND_N && t < 5000) begin
                    out_ready = ($urandom_range(9, 0) < 7);
                    if (out_valid && out_ready) begin
                        vectors++;
                        if (out_d !== rnd_ops[got] || out_q !== ref_root(rnd_ops[got]) || out_r !== ref_rem(rnd_ops[got])) begin
                            miscompares++;
                            $display("FAIL rnd_result%0d: got d=%0h q=%0d r=%0d want d=%0h q=%0d r=%0d", got, out_d, out_q, out_r,
                                     rnd_ops[got], ref_root(rnd_ops[got]), ref_rem(rnd_ops[got]));
                        end
                        qq = {48'd0, out_q}; rr = {47'd0, out_r}; dd = {32'd0, out_d};
                        vectors++;
                        if (qq * qq + rr != dd || rr > 2 * qq) begin
                            miscompares++;
                            $display("FAIL rnd_invariant%0d: d=%0d q=%0d r=%0d", got, out_d, out_q, out_r);
                        end
`ifdef SQRT_DISP_EXACT_EN
                        vectors++; if (out_exact !== (ref_rem(rnd_ops[got]) == 17'd0)) begin miscompares++; $display("FAIL rnd_exact%0d: got %0b", got, out_exact); end
`endif
                        got++;
                    end
                    @(negedge clk);
                    t++;
                end
                out_ready = 1'b0;
                vectors++; if (got != RND_N) begin miscompares++; $display("FAIL rnd_count: got %0d want %0d", got, RND_N); end
            end
        join
    endtask

    task automatic test_reset_midop();
        int bad;
        core_lat_min = 20; core_lat_max = 20;
        out_ready = 1'b1;
        send(32'd1000, 20);
        send(32'd2000, 20);
        send(32'd3000, 20);
        repeat (2) @(negedge clk);
        clrn = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
        vectors++; if (sq_start !== 1'b0 || sq_d !== 32'd0) begin miscompares++; $display("FAIL rst_issue_regs: sq_start=%0b sq_d=%0h want 0 0", sq_start, sq_d); end
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_in_ready: got %0b want 1", in_ready); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid !== 1'b0 || sq_start !== 1'b0) bad++;
            @(negedge clk);
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL rst_discard: %0d cycles with result or issue, want 0", bad); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_drain_push();
        test_spurious();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
